// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L1I/L1D to L2 request arbiter.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/l2_arb_grant.sv
// Combinational I/D grant. L1_L2_ARB_RR_EN selects round-robin on ties;
// otherwise the D side has fixed priority and no pointer register exists.
module l2_arb_grant
  import l2_arb_pkg::*;
(
`ifdef L1_L2_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic en,
  input  logic i_valid,
  input  logic d_valid,
  output logic grant_i,
  output logic grant_d
);

`ifdef L1_L2_ARB_RR_EN
  // Owner of the most recent grant; reset value "I" lets D win the first tie.
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_I;
    end else if (grant_i || grant_d) begin
      last_q <= grant_d ? OWN_D : OWN_I;
    end
  end

  always_comb begin
    grant_d = en && d_valid && (!i_valid || (last_q == OWN_I));
    grant_i = en && i_valid && !grant_d;
  end
`else
  always_comb begin
    grant_d = en && d_valid;
    grant_i = en && i_valid && !d_valid;
  end
`endif

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares one L2 request port between L1I and L1D, one transaction at a time,
// with a watchdog on the response. Build option: L1_L2_ARB_RR_EN (round-robin).
module l1_l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req_valid,
  input  logic [AW-1:0] i_req_addr,
  output logic          i_req_ready,
  output logic          i_resp_valid,
  output logic [DW-1:0] i_resp_data,
  input  logic          d_req_valid,
  input  logic [AW-1:0] d_req_addr,
  input  logic          d_req_we,
  input  logic [DW-1:0] d_req_wdata,
  output logic          d_req_ready,
  output logic          d_resp_valid,
  output logic [DW-1:0] d_resp_data,
  output logic          l2_valid_o,
  output logic [AW-1:0] l2_addr_o,
  output logic          l2_we_o,
  output logic [DW-1:0] l2_wdata_o,
  input  logic          l2_ready_i,
  input  logic          l2_valid_i,
  input  logic [DW-1:0] l2_rdata_i,
  output logic          err_o,
  output logic          busy_o
);

  // Handshakes: a request transfers on a cycle where *_req_valid && *_req_ready;
  // the L2 request transfers when l2_valid_o && l2_ready_i. Responses are
  // single-cycle strobes with no back-pressure.

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_e          state, state_nxt;
  logic            owner_q;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;
  logic [DW-1:0]   i_data_q, d_data_q;
  logic            grant_i, grant_d;
  logic            in_idle;
  logic            timeout_hit;
  logic [DW-1:0]   capture_data;

  assign in_idle      = (state == IDLE);
  assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == TO_LAST) && !l2_valid_i;
  assign capture_data = (l2_valid_i && !we_q) ? l2_rdata_i : '0;

  l2_arb_grant u_grant (
`ifdef L1_L2_ARB_RR_EN
    .clk     (clk),
    .rst_n   (rst_n),
`endif
    .en      (in_idle),
    .i_valid (i_req_valid),
    .d_valid (d_req_valid),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (grant_i || grant_d)         state_nxt = ISSUE;
      ISSUE: if (l2_ready_i)                 state_nxt = WAIT;
      WAIT:  if (l2_valid_i || timeout_hit)  state_nxt = RESP;
      RESP:                                  state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_req_ready  = grant_i;
    d_req_ready  = grant_d;
    l2_valid_o   = (state == ISSUE);
    i_resp_valid = (state == RESP) && (owner_q == OWN_I);
    d_resp_valid = (state == RESP) && (owner_q == OWN_D);
    err_o        = (state == RESP) && err_q;
    busy_o       = !in_idle;
  end

  // Each side keeps its own data register so it only changes on its own RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_I;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      i_data_q <= '0;
      d_data_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            owner_q <= OWN_D;
            addr_q  <= d_req_addr;
            we_q    <= d_req_we;
            wdata_q <= d_req_wdata;
          end else if (grant_i) begin
            owner_q <= OWN_I;
            addr_q  <= i_req_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
          end
        end
        ISSUE: if (l2_ready_i) cnt_q <= '0;
        WAIT: begin
          if (l2_valid_i || timeout_hit) begin
            if (owner_q == OWN_D) d_data_q <= capture_data;
            else                  i_data_q <= capture_data;
            err_q <= timeout_hit;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    err_q <= 1'b0;
        default: err_q <= 1'b0;
      endcase
    end
  end

  assign i_resp_data = i_data_q;
  assign d_resp_data = d_data_q;
  assign l2_addr_o   = addr_q;
  assign l2_we_o     = we_q;
  assign l2_wdata_o  = wdata_q;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter (TIMEOUT=4); expects round-robin ties when
// L1_L2_ARB_RR_EN is defined, fixed D priority otherwise.
module tb_l1_l2_arbiter;
  import l2_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          i_req_valid;
  logic [AW-1:0] i_req_addr;
  logic          i_req_ready;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_data;
  logic          d_req_valid;
  logic [AW-1:0] d_req_addr;
  logic          d_req_we;
  logic [DW-1:0] d_req_wdata;
  logic          d_req_ready;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_data;
  logic          l2_valid_o;
  logic [AW-1:0] l2_addr_o;
  logic          l2_we_o;
  logic [DW-1:0] l2_wdata_o;
  logic          l2_ready_i;
  logic          l2_valid_i;
  logic [DW-1:0] l2_rdata_i;
  logic          err_o;
  logic          busy_o;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  l1_l2_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4), .CW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .i_req_ready  (i_req_ready),
    .i_resp_valid (i_resp_valid),
    .i_resp_data  (i_resp_data),
    .d_req_valid  (d_req_valid),
    .d_req_addr   (d_req_addr),
    .d_req_we     (d_req_we),
    .d_req_wdata  (d_req_wdata),
    .d_req_ready  (d_req_ready),
    .d_resp_valid (d_resp_valid),
    .d_resp_data  (d_resp_data),
    .l2_valid_o   (l2_valid_o),
    .l2_addr_o    (l2_addr_o),
    .l2_we_o      (l2_we_o),
    .l2_wdata_o   (l2_wdata_o),
    .l2_ready_i   (l2_ready_i),
    .l2_valid_i   (l2_valid_i),
    .l2_rdata_i   (l2_rdata_i),
    .err_o        (err_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after the IDLE negedge with request inputs already driven.
  // Runs one transaction with immediate L2 ready and response.
  task automatic xact(input logic exp_d, input logic keep, input logic [AW-1:0] exp_addr,
                      input logic exp_we, input logic [DW-1:0] exp_wdata,
                      input logic [DW-1:0] rdata, input logic [DW-1:0] exp_rdata);
    logic [DW-1:0] want;
    exp_q.push_back(exp_rdata);
    #1;
    chk("grant_i_ready", i_req_ready, !exp_d);
    chk("grant_d_ready", d_req_ready, exp_d);
    @(negedge clk);
    if (!keep) begin
      if (exp_d) d_req_valid = 1'b0;
      else       i_req_valid = 1'b0;
    end
    l2_ready_i = 1'b1;
    #1;
    chk("issue_valid", l2_valid_o, 1'b1);
    chk("issue_addr", l2_addr_o, exp_addr);
    chk("issue_we", l2_we_o, exp_we);
    chk("issue_wdata", l2_wdata_o, exp_wdata);
    chk("issue_readies", {i_req_ready, d_req_ready}, 2'b00);
    @(negedge clk);
    l2_ready_i = 1'b0;
    l2_valid_i = 1'b1;
    l2_rdata_i = rdata;
    #1;
    chk("wait_l2_valid", l2_valid_o, 1'b0);
    @(negedge clk);
    l2_valid_i = 1'b0;
    l2_rdata_i = '0;
    #1;
    want = exp_q.pop_front();
    chk("resp_i_valid", i_resp_valid, !exp_d);
    chk("resp_d_valid", d_resp_valid, exp_d);
    chk("resp_data", exp_d ? d_resp_data : i_resp_data, want);
    chk("resp_err", err_o, 1'b0);
    @(negedge clk);
    #1;
    chk("back_idle", {busy_o, i_resp_valid, d_resp_valid}, 3'b000);
  endtask

  initial begin
    logic rr;
`ifdef L1_L2_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst_n = 1'b0;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0;
    l2_ready_i = 1'b0; l2_valid_i = 1'b0; l2_rdata_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_l2_valid", l2_valid_o, 1'b0);
    chk("rst_l2_addr", l2_addr_o, 32'h0);
    chk("rst_resp", {i_resp_valid, d_resp_valid, err_o}, 3'b000);
    chk("rst_readies", {i_req_ready, d_req_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests, three rounds with both sides holding valid
    @(negedge clk);
    i_req_valid = 1'b1; i_req_addr = 32'h0000_3000;
    d_req_valid = 1'b1; d_req_addr = 32'h0000_4000;
    xact(1'b1, 1'b1, 32'h4000, 1'b0, 32'h0, 32'h0000_0D01, 32'h0000_0D01);
    chk("tie_i_addr_kept", i_req_addr, 32'h3000);
    if (rr) xact(1'b0, 1'b1, 32'h3000, 1'b0, 32'h0, 32'h0000_0A02, 32'h0000_0A02);
    else    xact(1'b1, 1'b1, 32'h4000, 1'b0, 32'h0, 32'h0000_0D02, 32'h0000_0D02);
    xact(1'b1, 1'b1, 32'h4000, 1'b0, 32'h0, 32'h0000_0D03, 32'h0000_0D03);
    d_req_valid = 1'b0;
    xact(1'b0, 1'b0, 32'h3000, 1'b0, 32'h0, 32'h0000_0A04, 32'h0000_0A04);

    // I read alone
    i_req_valid = 1'b1; i_req_addr = 32'h0000_1040;
    xact(1'b0, 1'b0, 32'h1040, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    chk("i_data_hold", i_resp_data, 32'hDEAD_BEEF);

    // D write: response data is 0 regardless of L2 rdata
    d_req_valid = 1'b1; d_req_addr = 32'h0000_2000; d_req_we = 1'b1; d_req_wdata = 32'h1234_5678;
    xact(1'b1, 1'b0, 32'h2000, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 32'h0);
    chk("i_data_hold_after_d", i_resp_data, 32'hDEAD_BEEF);
    d_req_we = 1'b0; d_req_wdata = '0;

    // L2 stall: ISSUE held 5 cycles
    d_req_valid = 1'b1; d_req_addr = 32'h0000_5000;
    #1;
    chk("stall_d_ready", d_req_ready, 1'b1);
    @(negedge clk);
    d_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_valid", l2_valid_o, 1'b1);
      chk("stall_addr", l2_addr_o, 32'h5000);
      chk("stall_we", l2_we_o, 1'b0);
      @(negedge clk);
    end
    l2_ready_i = 1'b1;
    #1;
    chk("stall_release_valid", l2_valid_o, 1'b1);
    @(negedge clk);
    l2_ready_i = 1'b0; l2_valid_i = 1'b1; l2_rdata_i = 32'h55AA_55AA;
    @(negedge clk);
    l2_valid_i = 1'b0; l2_rdata_i = '0;
    #1;
    chk("stall_resp_valid", d_resp_valid, 1'b1);
    chk("stall_resp_data", d_resp_data, 32'h55AA_55AA);
    @(negedge clk);

    // Watchdog: no L2 response, forced completion after 4 WAIT cycles
    i_req_valid = 1'b1; i_req_addr = 32'h0000_6000;
    @(negedge clk);
    i_req_valid = 1'b0; l2_ready_i = 1'b1;
    #1;
    chk("wd_issue", l2_valid_o, 1'b1);
    @(negedge clk);
    l2_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("wd_waiting", {busy_o, i_resp_valid, err_o, l2_valid_o}, 4'b1000);
      @(negedge clk);
    end
    #1;
    chk("wd_resp_valid", i_resp_valid, 1'b1);
    chk("wd_resp_data", i_resp_data, 32'h0);
    chk("wd_err", err_o, 1'b1);
    @(negedge clk);
    l2_valid_i = 1'b1; l2_rdata_i = 32'h0BAD_0BAD;
    #1;
    chk("late_idle", {busy_o, err_o}, 2'b00);
    @(negedge clk);
    l2_valid_i = 1'b0; l2_rdata_i = '0;
    #1;
    chk("late_dropped", {busy_o, i_resp_valid, d_resp_valid, err_o}, 4'b0000);
    chk("late_data", i_resp_data, 32'h0);

    // Reset asserted in WAIT
    d_req_valid = 1'b1; d_req_addr = 32'h0000_7000;
    @(negedge clk);
    d_req_valid = 1'b0; l2_ready_i = 1'b1;
    @(negedge clk);
    l2_ready_i = 1'b0;
    #1;
    chk("pre_rst_busy", busy_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_outs", {l2_valid_o, i_resp_valid, d_resp_valid, err_o}, 4'b0000);
    chk("mid_rst_addr", l2_addr_o, 32'h0);
    chk("mid_rst_d_data", d_resp_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d_req_valid = 1'b1; d_req_addr = 32'h0000_8000;
    xact(1'b1, 1'b0, 32'h8000, 1'b0, 32'h0, 32'h8765_4321, 32'h8765_4321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
